// File: rtl/tmr_serial_tx_if.sv
// Word handshake between a producer and tmr_serial_tx, plus the per-frame
// fault-injection controls that are sampled on the same handshake edge.
interface tmr_serial_tx_if #(
    parameter int DATA_BITS = 8
);
    logic                 in_val;
    logic                 in_rdy;
    logic [DATA_BITS-1:0] in_data;
    logic                 fault_en;
    logic [1:0]           fault_lane;

    modport master (
        output in_val,
        output in_data,
        output fault_en,
        output fault_lane,
        input  in_rdy
    );

    modport slave (
        input  in_val,
        input  in_data,
        input  fault_en,
        input  fault_lane,
        output in_rdy
    );
endinterface

// File: rtl/tmr_serial_tx.sv
// Triple-redundant UART-style transmitter: start, DATA_BITS data bits LSB first,
// stop, replicated on three lanes with optional inversion of one lane per frame.
module tmr_serial_tx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    tmr_serial_tx_if.slave  bus,
    output logic            lane0,
    output logic            lane1,
    output logic            lane2,
    output logic            busy
);
    localparam int              CW       = $clog2(DATA_BITS + 1);
    localparam logic [7:0]      DIV_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_dn;
    logic [7:0]           div_reg;
    logic [CW-1:0]        cnt_reg;
    logic [2:0]           mask_reg;
    logic [2:0]           mask_next;
    logic [2:0]           lanes_reg;
    logic                 busy_reg;
    logic                 bit_done;

    // fault_lane == 3 matches no lane, giving an all-zero mask
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_mask
            assign mask_next[gi] = bus.fault_en && (bus.fault_lane == 2'(gi));
        end
    endgenerate

    assign bit_done   = (div_reg == DIV_LAST);
    assign shift_dn   = shift_reg >> 1;
    assign bus.in_rdy = (state_reg == IDLE);
    assign lane0      = lanes_reg[0];
    assign lane1      = lanes_reg[1];
    assign lane2      = lanes_reg[2];
    assign busy       = busy_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            div_reg   <= '0;
            cnt_reg   <= '0;
            mask_reg  <= '0;
            lanes_reg <= 3'b111;
            busy_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.in_val) begin
                        shift_reg <= bus.in_data;
                        mask_reg  <= mask_next;
                        div_reg   <= '0;
                        cnt_reg   <= '0;
                        state_reg <= START;
                        busy_reg  <= 1'b1;
                        lanes_reg <= mask_next;          // start bit 0, masked
                    end
                end
                START: begin
                    if (bit_done) begin
                        div_reg   <= '0;
                        state_reg <= DATA;
                        lanes_reg <= {3{shift_reg[0]}} ^ mask_reg;
                    end else begin
                        div_reg <= div_reg + 8'd1;
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        div_reg <= '0;
                        if (cnt_reg == CNT_LAST) begin
                            state_reg <= STOP;
                            lanes_reg <= ~mask_reg;      // stop bit 1, masked
                        end else begin
                            // lanes pick up the next bit as the register shifts
                            shift_reg <= shift_dn;
                            cnt_reg   <= cnt_reg + CW'(1);
                            lanes_reg <= {3{shift_dn[0]}} ^ mask_reg;
                        end
                    end else begin
                        div_reg <= div_reg + 8'd1;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        div_reg   <= '0;
                        state_reg <= IDLE;
                        lanes_reg <= 3'b111;
                        busy_reg  <= 1'b0;
                    end else begin
                        div_reg <= div_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    lanes_reg <= 3'b111;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tmr_serial_tx.sv
// Scoreboard bench for tmr_serial_tx: two instances (CLKS_PER_BIT=1 and 4)
// share clk/rst; expected per-cycle lane/rdy/busy samples are queued per frame.
module tb_tmr_serial_tx;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tmr_serial_tx_if #(.DATA_BITS(8)) bus1 ();
    tmr_serial_tx_if #(.DATA_BITS(8)) bus4 ();

    logic l0_1, l1_1, l2_1, busy1;
    logic l0_4, l1_4, l2_4, busy4;
    logic [2:0] ln1, ln4;
    assign ln1 = {l2_1, l1_1, l0_1};
    assign ln4 = {l2_4, l1_4, l0_4};

    tmr_serial_tx #(.DATA_BITS(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave),
        .lane0(l0_1), .lane1(l1_1), .lane2(l2_1), .busy(busy1)
    );
    tmr_serial_tx #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4.slave),
        .lane0(l0_4), .lane1(l1_4), .lane2(l2_4), .busy(busy4)
    );

    typedef struct packed {
        logic [2:0] ln;
        logic       rdy;
        logic       bsy;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Frame model: start 0, data LSB first, stop 1, each held cpb cycles,
    // then the single idle sample where in_rdy is back.
    function automatic void push_frame(input logic [7:0] data, input int cpb,
                                       input logic [2:0] mask);
        logic nom;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      nom = 1'b0;
            else if (k == 9) nom = 1'b1;
            else             nom = data[k-1];
            for (int c = 0; c < cpb; c++)
                exp_q.push_back('{ln: {3{nom}} ^ mask, rdy: 1'b0, bsy: 1'b1});
        end
        exp_q.push_back('{ln: 3'b111, rdy: 1'b1, bsy: 1'b0});
    endfunction

    // Handshake on one instance; returns at the first sample after the handshake edge.
    task automatic drive(input bit fast, input logic [7:0] d, input logic fen,
                         input logic [1:0] fl);
        @(negedge clk);
        if (fast) begin
            bus1.in_val = 1'b1; bus1.in_data = d; bus1.fault_en = fen; bus1.fault_lane = fl;
        end else begin
            bus4.in_val = 1'b1; bus4.in_data = d; bus4.fault_en = fen; bus4.fault_lane = fl;
        end
        @(negedge clk);
        bus1.in_val = 1'b0;
        bus4.in_val = 1'b0;
    endtask

    task automatic test_reset;
        exp_t e, o;
        int   n;
        repeat (2) @(negedge clk);
        total++;
        if ({ln1, bus1.in_rdy, busy1} !== 5'b11110) begin
            bad++;
            $display("FAIL reset_fast got lanes=%b rdy=%b busy=%b want lanes=111 rdy=1 busy=0",
                     ln1, bus1.in_rdy, busy1);
        end
        total++;
        if ({ln4, bus4.in_rdy, busy4} !== 5'b11110) begin
            bad++;
            $display("FAIL reset_slow got lanes=%b rdy=%b busy=%b want lanes=111 rdy=1 busy=0",
                     ln4, bus4.in_rdy, busy4);
        end
        rst = 1'b0;
        // abandon a frame in the middle of its data bits
        drive(1'b0, 8'hA5, 1'b0, 2'd0);
        repeat (7) @(negedge clk);
        total++;
        if (busy4 !== 1'b1) begin
            bad++;
            $display("FAIL reset_pre_busy got busy=%b want busy=1", busy4);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({ln4, bus4.in_rdy, busy4} !== 5'b11110) begin
            bad++;
            $display("FAIL reset_midframe got lanes=%b rdy=%b busy=%b want lanes=111 rdy=1 busy=0",
                     ln4, bus4.in_rdy, busy4);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({ln4, bus4.in_rdy, busy4} !== 5'b11110) begin
            bad++;
            $display("FAIL reset_release got lanes=%b rdy=%b busy=%b want lanes=111 rdy=1 busy=0",
                     ln4, bus4.in_rdy, busy4);
        end
        push_frame(8'h5A, 4, 3'b000);
        drive(1'b0, 8'h5A, 1'b0, 2'd0);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '{ln: ln4, rdy: bus4.in_rdy, bsy: busy4};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL post_reset_frame cyc=%0d got %b want %b (lanes,rdy,busy)", n, o, e);
            end
            n++;
            @(negedge clk);
        end
        $display("reset: mid-frame reset, then frame 0x5A (%0d samples)", n);
    endtask

    task automatic test_single;
        exp_t e, o;
        int   n;
        push_frame(8'hA5, 1, 3'b000);
        drive(1'b1, 8'hA5, 1'b0, 2'd0);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '{ln: ln1, rdy: bus1.in_rdy, bsy: busy1};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL single_a5 cyc=%0d got %b want %b (lanes,rdy,busy)", n, o, e);
            end
            n++;
            @(negedge clk);
        end
        $display("single: frame 0xA5 cpb=1 (%0d samples)", n);
    endtask

    task automatic test_bit_hold;
        exp_t e, o;
        int   n;
        push_frame(8'h01, 4, 3'b000);
        drive(1'b0, 8'h01, 1'b0, 2'd0);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '{ln: ln4, rdy: bus4.in_rdy, bsy: busy4};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL bit_hold cyc=%0d got %b want %b (lanes,rdy,busy)", n, o, e);
            end
            n++;
            @(negedge clk);
        end
        $display("bit_hold: frame 0x01 cpb=4 (%0d samples)", n);
    endtask

    task automatic test_fault;
        exp_t e, o;
        int   n;
        logic vote;
        push_frame(8'h3C, 1, 3'b010);
        drive(1'b1, 8'h3C, 1'b1, 2'd1);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '{ln: ln1, rdy: bus1.in_rdy, bsy: busy1};
            vote = (l0_1 & l1_1) | (l1_1 & l2_1) | (l0_1 & l2_1);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL fault_lane1 cyc=%0d got %b want %b (lanes,rdy,busy)", n, o, e);
            end
            total++;
            if (vote !== e.ln[0]) begin
                bad++;
                $display("FAIL fault_vote cyc=%0d got vote=%b want %b", n, vote, e.ln[0]);
            end
            n++;
            @(negedge clk);
        end
        $display("fault: frame 0x3C lane1 inverted (%0d samples)", n);
        push_frame(8'h3C, 1, 3'b000);
        drive(1'b1, 8'h3C, 1'b1, 2'd3);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '{ln: ln1, rdy: bus1.in_rdy, bsy: busy1};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL fault_lane3 cyc=%0d got %b want %b (lanes,rdy,busy)", n, o, e);
            end
            n++;
            @(negedge clk);
        end
        bus1.fault_en = 1'b0;
        $display("fault: frame 0x3C fault_lane=3, no inversion (%0d samples)", n);
    endtask

    task automatic test_back_to_back;
        exp_t e, o;
        int   n;
        push_frame(8'h00, 1, 3'b000);
        push_frame(8'hFF, 1, 3'b000);
        @(negedge clk);
        bus1.in_val = 1'b1; bus1.in_data = 8'h00; bus1.fault_en = 1'b0; bus1.fault_lane = 2'd0;
        @(negedge clk);
        n = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '{ln: ln1, rdy: bus1.in_rdy, bsy: busy1};
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL back_to_back cyc=%0d got %b want %b (lanes,rdy,busy)", n, o, e);
            end
            // inputs change while frames are in flight; only handshake edges may sample them
            if (n == 3) begin
                bus1.in_data = 8'hFF; bus1.fault_en = 1'b1;
            end else if (n == 9) begin
                bus1.fault_en = 1'b0;
            end else if (n == 11) begin
                bus1.in_val = 1'b0; bus1.in_data = 8'h00;
                bus1.fault_en = 1'b1; bus1.fault_lane = 2'd2;
            end
            n++;
            @(negedge clk);
        end
        bus1.fault_en = 1'b0;
        $display("back_to_back: frames 0x00 then 0xFF (%0d samples)", n);
    endtask

    task automatic test_stall;
        bus1.in_val = 1'b0;
        bus4.in_val = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if ({ln1, bus1.in_rdy, busy1, ln4, bus4.in_rdy, busy4} !== 10'b1111011110) begin
                bad++;
                $display("FAIL stall cyc=%0d got fast=%b/%b/%b slow=%b/%b/%b want 111/1/0",
                         i, ln1, bus1.in_rdy, busy1, ln4, bus4.in_rdy, busy4);
            end
        end
        $display("stall: 20 idle cycles");
    endtask

    initial begin
        bus1.in_val = 1'b0; bus1.in_data = '0; bus1.fault_en = 1'b0; bus1.fault_lane = 2'd0;
        bus4.in_val = 1'b0; bus4.in_data = '0; bus4.fault_en = 1'b0; bus4.fault_lane = 2'd0;
        test_reset();
        test_single();
        test_bit_hold();
        test_fault();
        test_back_to_back();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end
endmodule
